// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM bus arbiter: owner tags, lock-FSM states
// and the default outstanding-transaction depth.
package sram_bus_arbiter_pkg;

  // Tag stored per accepted transaction so the in-order response finds its owner.
  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // Lock FSM: IDLE arbitrates freely, HOLD_x pins the port to x until accepted.
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_HOLD_INST = 2'd1,
    ARB_HOLD_DATA = 2'd2
  } arb_state_e;

  localparam int DEFAULT_MAX_OUT = 2;

  // Hold state that pins the port to the given owner.
  function automatic arb_state_e hold_state(input owner_e owner);
    return (owner == OWNER_DATA) ? ARB_HOLD_DATA : ARB_HOLD_INST;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Small synchronous FIFO of 1-bit owner tags. Records who issued each
// accepted memory request so responses can be routed back in order.
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Next pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage, written on push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count_q == 0 already marks every entry invalid.
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok port between the IF-stage
// instruction requester and the EX-stage data requester. Data has priority
// in IDLE; a request not accepted immediately locks the port to its owner
// until mem_addr_ok. Accepted owners are queued so in-order responses are
// routed back to the right requester.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = DEFAULT_MAX_OUT
) (
  input  logic              clk,
  input  logic              reset,
  // IF-side requester
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [3:0]        inst_wstrb,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // EX-side requester
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_wstrb,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // Shared memory port
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  // Sticky protocol error
  output logic              arb_err
);

  arb_state_e state_q, state_d;
  owner_e     owner;
  logic       sel_req;
  logic       req_int;
  logic       handshake;
  logic       fifo_full, fifo_empty, fifo_head, fifo_pop;
  logic       arb_err_q, arb_err_d;
  logic       own_data;

  // Pick this cycle's owner, gate the request on FIFO space, and advance the lock.
  always_comb begin
    state_d = state_q;
    owner   = OWNER_INST;
    unique case (state_q)
      ARB_HOLD_INST: owner = OWNER_INST;
      ARB_HOLD_DATA: owner = OWNER_DATA;
      default:       owner = data_req ? OWNER_DATA : OWNER_INST;
    endcase
    sel_req   = (owner == OWNER_DATA) ? data_req : inst_req;
    req_int   = sel_req & ~fifo_full & ~reset;
    handshake = req_int & mem_addr_ok;
    if (req_int & ~mem_addr_ok) begin
      state_d = hold_state(owner);
    end else if (handshake) begin
      state_d = ARB_IDLE;
    end
  end

  // Sticky error: a response arrived while nothing was outstanding.
  always_comb begin
    arb_err_d = arb_err_q | (mem_data_ok & fifo_empty);
  end

  // Lock state and error flag, cleared asynchronously with the bridge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign fifo_pop = mem_data_ok & ~fifo_empty;

  arb_owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (handshake),
    .pop   (fifo_pop),
    .din   (owner),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Zero-latency mux of the owner's fields onto the memory port; all zero in reset.
  assign own_data  = (owner == OWNER_DATA);
  assign mem_req   = req_int;
  assign mem_wr    = reset ? 1'b0 : (own_data ? data_wr    : inst_wr);
  assign mem_size  = reset ? '0   : (own_data ? data_size  : inst_size);
  assign mem_addr  = reset ? '0   : (own_data ? data_addr  : inst_addr);
  assign mem_wstrb = reset ? '0   : (own_data ? data_wstrb : inst_wstrb);
  assign mem_wdata = reset ? '0   : (own_data ? data_wdata : inst_wdata);

  // Acceptance goes only to the current owner.
  assign inst_addr_ok = handshake & ~own_data;
  assign data_addr_ok = handshake & own_data;

  // Responses follow the oldest outstanding owner tag.
  assign inst_data_ok = fifo_pop & (fifo_head == OWNER_INST);
  assign data_data_ok = fifo_pop & (fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign arb_err = arb_err_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter. The initial block acts as both
// requesters and the memory; whenever it presents mem_data_ok for a tracked
// transaction it queues the expected {owner, rdata}, and a negedge monitor
// pops and compares each time the DUT raises a *_data_ok.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              inst_req, inst_wr;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic [3:0]        inst_wstrb;
  logic [DATA_W-1:0] inst_wdata;
  logic              inst_addr_ok, inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req, data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok, data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req, mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok, mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;
  logic              arb_err;

  typedef struct {
    logic              owner;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   passed;

  sram_bus_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_OUT (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wstrb   (inst_wstrb),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .arb_err      (arb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic expect_resp(input logic owner, input logic [DATA_W-1:0] rdata);
    exp_t e;
    e.owner = owner;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    inst_req    = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0;
    inst_wstrb  = 4'h0; inst_wdata = '0;
    data_req    = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0;
    data_wstrb  = 4'h0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  // Response monitor: every data_ok must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t              e;
    logic [DATA_W-1:0] got;
    if (!reset && (inst_data_ok || data_data_ok)) begin
      total++;
      got = data_data_ok ? data_rdata : inst_rdata;
      if (inst_data_ok && data_data_ok) begin
        $display("FAIL resp_both: inst_data_ok and data_data_ok both 1, expected one");
      end else if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected: inst_data_ok=%0b data_data_ok=%0b expected none",
                 inst_data_ok, data_data_ok);
      end else begin
        e = exp_q.pop_front();
        if (data_data_ok == e.owner && got == e.rdata) passed++;
        else $display("FAIL resp_route: owner %0b rdata 0x%08h expected owner %0b rdata 0x%08h",
                      data_data_ok, got, e.owner, e.rdata);
      end
    end
  end

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    clear_inputs();
    inst_req    = 1'b1;
    data_req    = 1'b1;
    mem_data_ok = 1'b1;

    // Reset state: everything quiet even with live inputs.
    sample();
    check_bit("rst_mem_req", mem_req, 1'b0);
    check_word("rst_mem_addr", mem_addr, 32'h0);
    check_bit("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    check_bit("rst_data_addr_ok", data_addr_ok, 1'b0);
    check_bit("rst_inst_data_ok", inst_data_ok, 1'b0);
    check_bit("rst_data_data_ok", data_data_ok, 1'b0);
    check_bit("rst_arb_err", arb_err, 1'b0);

    next_cycle();
    reset = 1'b0;
    clear_inputs();

    // Single instruction fetch accepted same cycle, answered next cycle.
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
    sample();
    check_bit("t1_mem_req", mem_req, 1'b1);
    check_word("t1_mem_addr", mem_addr, 32'h1C00_0000);
    check_bit("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    check_bit("t1_data_addr_ok", data_addr_ok, 1'b0);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h02C0_0000;
    expect_resp(OWNER_INST, 32'h02C0_0000);
    sample();
    check_bit("t1_inst_data_ok", inst_data_ok, 1'b1);
    check_bit("t1_data_data_ok", data_data_ok, 1'b0);

    // Simultaneous requests: data store wins, fetch accepted next cycle.
    next_cycle();
    clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_addr = 32'h0000_1000; data_wr = 1'b1;
    data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1'b1;
    sample();
    check_bit("t2_data_addr_ok", data_addr_ok, 1'b1);
    check_bit("t2_inst_addr_ok_0", inst_addr_ok, 1'b0);
    check_word("t2_mem_addr_data", mem_addr, 32'h0000_1000);
    check_bit("t2_mem_wr", mem_wr, 1'b1);
    check_word("t2_mem_wstrb", 32'(mem_wstrb), 32'hF);
    check_word("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    data_req = 1'b0;
    sample();
    check_bit("t2_inst_addr_ok", inst_addr_ok, 1'b1);
    check_bit("t2_data_addr_ok_0", data_addr_ok, 1'b0);
    check_word("t2_mem_addr_inst", mem_addr, 32'h1C00_0004);
    check_bit("t2_mem_wr_0", mem_wr, 1'b0);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h0;
    expect_resp(OWNER_DATA, 32'h0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
    expect_resp(OWNER_INST, 32'h1111_2222);
    next_cycle();
    clear_inputs();

    // Fetch held three cycles; data request arriving meanwhile must wait.
    inst_req = 1'b1; inst_addr = 32'h1C00_0008;
    sample();
    check_bit("t3_mem_req", mem_req, 1'b1);
    check_word("t3_hold_c1", mem_addr, 32'h1C00_0008);
    check_bit("t3_no_addr_ok", inst_addr_ok, 1'b0);
    next_cycle();
    data_req = 1'b1; data_addr = 32'h0000_2000;
    sample();
    check_word("t3_hold_c2", mem_addr, 32'h1C00_0008);
    check_bit("t3_data_ignored", data_addr_ok, 1'b0);
    next_cycle();
    sample();
    check_word("t3_hold_c3", mem_addr, 32'h1C00_0008);
    next_cycle();
    mem_addr_ok = 1'b1;
    sample();
    check_bit("t3_inst_accept", inst_addr_ok, 1'b1);
    check_bit("t3_data_wait", data_addr_ok, 1'b0);
    next_cycle();
    inst_req = 1'b0;
    sample();
    check_bit("t3_data_accept", data_addr_ok, 1'b1);
    check_word("t3_mem_addr_data", mem_addr, 32'h0000_2000);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0001;
    expect_resp(OWNER_INST, 32'hAAAA_0001);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'hBBBB_0002;
    expect_resp(OWNER_DATA, 32'hBBBB_0002);
    next_cycle();
    clear_inputs();

    // Two outstanding fills the owner FIFO; further requests are blocked.
    inst_req = 1'b1; inst_addr = 32'h0000_0100; mem_addr_ok = 1'b1;
    sample();
    check_bit("t4_acc1", inst_addr_ok, 1'b1);
    next_cycle();
    inst_addr = 32'h0000_0104;
    sample();
    check_bit("t4_acc2", inst_addr_ok, 1'b1);
    next_cycle();
    inst_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_3000;
    sample();
    check_bit("t4_full_mem_req", mem_req, 1'b0);
    check_bit("t4_full_no_addr_ok", data_addr_ok, 1'b0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'hC000_0100;
    expect_resp(OWNER_INST, 32'hC000_0100);
    sample();
    check_bit("t4_full_pop_mem_req", mem_req, 1'b0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'hC000_0104;
    expect_resp(OWNER_INST, 32'hC000_0104);
    sample();
    check_bit("t4_pushpop_accept", data_addr_ok, 1'b1);
    next_cycle();
    data_req = 1'b0; mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0108;
    sample();
    check_bit("t4_refill", inst_addr_ok, 1'b1);
    next_cycle();
    inst_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_3004;
    sample();
    check_bit("t4_full_again", mem_req, 1'b0);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'hD000_3000;
    expect_resp(OWNER_DATA, 32'hD000_3000);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'hC000_0108;
    expect_resp(OWNER_INST, 32'hC000_0108);
    next_cycle();
    clear_inputs();

    // Spurious response with nothing outstanding: dropped, sticky error.
    mem_data_ok = 1'b1; mem_rdata = 32'hEEEE_EEEE;
    sample();
    check_bit("t5_no_inst_data_ok", inst_data_ok, 1'b0);
    check_bit("t5_no_data_data_ok", data_data_ok, 1'b0);
    next_cycle();
    clear_inputs();
    sample();
    check_bit("t5_arb_err_set", arb_err, 1'b1);
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h0000_0200; mem_addr_ok = 1'b1;
    sample();
    check_bit("t5_arb_err_sticky1", arb_err, 1'b1);
    check_bit("t5_traffic_ok", inst_addr_ok, 1'b1);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
    expect_resp(OWNER_INST, 32'h1234_5678);
    sample();
    check_bit("t5_arb_err_sticky2", arb_err, 1'b1);
    next_cycle();
    clear_inputs();

    // Reset mid-cycle with two outstanding transactions.
    inst_req = 1'b1; inst_addr = 32'h0000_0300; mem_addr_ok = 1'b1;
    next_cycle();
    inst_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_4000;
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0304;
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0055;
    #1 reset = 1'b1;
    sample();
    check_bit("t6_mem_req", mem_req, 1'b0);
    check_word("t6_mem_addr", mem_addr, 32'h0);
    check_bit("t6_inst_data_ok", inst_data_ok, 1'b0);
    check_bit("t6_data_data_ok", data_data_ok, 1'b0);
    check_bit("t6_inst_addr_ok", inst_addr_ok, 1'b0);
    check_bit("t6_arb_err_clr", arb_err, 1'b0);
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0066;
    sample();
    check_bit("t6_fifo_empty_inst", inst_data_ok, 1'b0);
    check_bit("t6_fifo_empty_data", data_data_ok, 1'b0);
    next_cycle();
    clear_inputs();
    sample();
    check_bit("t6_late_resp_err", arb_err, 1'b1);

    // Reset while a fetch is held returns the lock to IDLE.
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h0000_0500;
    sample();
    check_word("t7_held_addr", mem_addr, 32'h0000_0500);
    next_cycle();
    #1 reset = 1'b1;
    sample();
    check_bit("t7_rst_mem_req", mem_req, 1'b0);
    next_cycle();
    reset = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_6000;
    sample();
    check_word("t7_idle_priority", mem_addr, 32'h0000_6000);
    check_bit("t7_arb_err_clr", arb_err, 1'b0);
    next_cycle();
    clear_inputs();
    next_cycle();
    next_cycle();

    check_word("resp_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
